// File: rtl/fft_6th_stage_bitrev.sv
// ---------------------------------------------------------------------------
// fft_6th_stage_bitrev
//
// Last stage of the 64-point radix-2 single-delay-feedback FFT. The incoming
// serial stream from the 5th stage is combined pairwise with a one-sample
// delay line (the twiddle factor is always W^0, so there is no multiplier).
// The resulting bit-reversed sequence is then put back into natural bin
// order through a ping-pong reorder buffer.
//
// Ports
//   clk           stage clock
//   rst           asynchronous, active-high reset
//   start_conv    level; high from the first sample of the first frame and
//                 held high while frames stream back-to-back
//   serial_in_r   signed real input sample (DW bits)
//   serial_in_i   signed imaginary input sample (DW bits)
//   serial_out_r  signed real output, natural bin order
//   serial_out_i  signed imaginary output, natural bin order
//   out_valid     high while serial_out_* carries a valid bin
//   frame_start   one-cycle pulse alongside bin X[0] of every frame
// ---------------------------------------------------------------------------
module fft_6th_stage_bitrev #(
    parameter  int INTEGER_SIZE = 6,
    parameter  int FRACT_SIZE   = 12,
    parameter  int NFFT         = 64,
    localparam int DW           = INTEGER_SIZE + FRACT_SIZE,
    localparam int LOG2N        = $clog2(NFFT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_conv,
    input  logic signed [DW-1:0] serial_in_r,
    input  logic signed [DW-1:0] serial_in_i,
    output logic signed [DW-1:0] serial_out_r,
    output logic signed [DW-1:0] serial_out_i,
    output logic                 out_valid,
    output logic                 frame_start
);

    // Sample counter: value n while x[n] of the current frame is presented.
    logic [LOG2N-1:0] n_cnt;

    // Butterfly delay line and stage output register.
    logic signed [DW-1:0] delay_r, delay_i;
    logic signed [DW-1:0] stage_r, stage_i;

    // wr_run: stage register holds meaningful results (from the 3rd cycle on).
    // rd_run: one bank has been completely written and is being read out.
    logic wr_run;
    logic rd_run;
    logic wbank;
    logic wr_en;

    // Sequential index (stage output m on the write side, bin k on the read
    // side) and its bit-reversed counterpart.
    logic [LOG2N-1:0] seq_idx;
    logic [LOG2N-1:0] rev_idx;

    // Two banks of NFFT complex entries, addressed as {bank, index}.
    logic [2*DW-1:0] ram [0:2*NFFT-1];

    // The stage register is two cycles behind the sample counter, and the
    // registered read output is two cycles behind it as well, so both the
    // write index m and the read bin k equal n-2 (mod NFFT).
    always_comb begin
        seq_idx = n_cnt - LOG2N'(2);
        rev_idx = '0;
        for (int b = 0; b < LOG2N; b++) begin
            rev_idx[b] = seq_idx[LOG2N-1-b];
        end
    end

    assign wr_en = start_conv && wr_run;

    // Reorder RAM write port. Contents are never reset: out_valid tells the
    // consumer when the read data is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[{wbank, rev_idx}] <= {stage_r, stage_i};
        end
    end

    // Butterfly, bank control and registered output. Dropping start_conv
    // returns everything to its idle state on the next edge, discarding a
    // partially written bank, while serial_out keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_cnt        <= '0;
            delay_r      <= '0;
            delay_i      <= '0;
            stage_r      <= '0;
            stage_i      <= '0;
            wr_run       <= 1'b0;
            rd_run       <= 1'b0;
            wbank        <= 1'b0;
            serial_out_r <= '0;
            serial_out_i <= '0;
            out_valid    <= 1'b0;
            frame_start  <= 1'b0;
        end else if (!start_conv) begin
            n_cnt       <= '0;
            delay_r     <= '0;
            delay_i     <= '0;
            stage_r     <= '0;
            stage_i     <= '0;
            wr_run      <= 1'b0;
            rd_run      <= 1'b0;
            wbank       <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            n_cnt <= n_cnt + LOG2N'(1);

            // Even sample: park it and emit the previous pair's difference.
            // Odd sample: emit the pair sum and keep the difference.
            if (!n_cnt[0]) begin
                delay_r <= serial_in_r;
                delay_i <= serial_in_i;
                stage_r <= delay_r;
                stage_i <= delay_i;
            end else begin
                stage_r <= delay_r + serial_in_r;
                stage_i <= delay_i + serial_in_i;
                delay_r <= delay_r - serial_in_r;
                delay_i <= delay_i - serial_in_i;
            end

            // First stage result (pair 0 sum) is ready after the n=1 edge.
            if (n_cnt == LOG2N'(1)) begin
                wr_run <= 1'b1;
            end

            // With wr_run already set, the n=1 edge writes m=NFFT-1, which
            // completes the bank: swap and start reading it.
            if (wr_run && n_cnt == LOG2N'(1)) begin
                wbank  <= ~wbank;
                rd_run <= 1'b1;
            end

            out_valid   <= rd_run;
            frame_start <= rd_run && (seq_idx == '0);
            if (rd_run) begin
                {serial_out_r, serial_out_i} <= ram[{~wbank, seq_idx}];
            end
        end
    end

endmodule

// File: tb/tb_fft_6th_stage_bitrev.sv
// ---------------------------------------------------------------------------
// tb_fft_6th_stage_bitrev
//
// Drives directed frames into fft_6th_stage_bitrev and checks every cycle
// against a behavioural model: each bin X[k] is the sum (bitrev(k) even) or
// difference (bitrev(k) odd) of input pair bitrev(k)/2 of its frame, and
// appears 67 cycles after the frame's run started plus 64 per frame plus k.
// Hand-computed literal values pin the model on selected bins.
// ---------------------------------------------------------------------------
module tb_fft_6th_stage_bitrev;

    localparam int DW   = 18;
    localparam int NFFT = 64;
    localparam int LAT  = 67;
    localparam int MAXC = 2048;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_conv;
    logic [DW-1:0] serial_in_r;
    logic [DW-1:0] serial_in_i;
    logic [DW-1:0] serial_out_r;
    logic [DW-1:0] serial_out_i;
    logic          out_valid;
    logic          frame_start;

    int cyc = 0;
    int num_checks = 0;
    int num_fail = 0;
    int rst_events = 0;
    int seen_rst = 0;

    logic [DW-1:0] last_r = '0;
    logic [DW-1:0] last_i = '0;

    // Per-cycle record of what the DUT sampled, and what it produced.
    logic [DW-1:0] stim_r [MAXC];
    logic [DW-1:0] stim_i [MAXC];
    bit            stim_s [MAXC];
    logic          cap_v  [MAXC];
    logic          cap_fs [MAXC];
    logic [DW-1:0] cap_r  [MAXC];
    logic [DW-1:0] cap_i  [MAXC];

    int c1, c2, c3, d3, c4, d4;

    fft_6th_stage_bitrev dut (
        .clk          (clk),
        .rst          (rst),
        .start_conv   (start_conv),
        .serial_in_r  (serial_in_r),
        .serial_in_i  (serial_in_i),
        .serial_out_r (serial_out_r),
        .serial_out_i (serial_out_i),
        .out_valid    (out_valid),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h cycle=%0d",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic sc, input logic [DW-1:0] r,
                                 input logic [DW-1:0] im);
        @(posedge clk);
        #1;
        start_conv  = sc;
        serial_in_r = r;
        serial_in_i = im;
    endtask

    function automatic int bitrev6(input int k);
        int m = 0;
        for (int b = 0; b < 6; b++) begin
            if (((k >> b) & 1) != 0) m = m | (1 << (5 - b));
        end
        return m;
    endfunction

    // Expected bin k of the frame whose x[0] was sampled in cycle base.
    function automatic logic [DW-1:0] model_bin(input int base, input int k,
                                                input bit imag);
        int m = bitrev6(k);
        int p = m / 2;
        logic [DW-1:0] a, b;
        a = imag ? stim_i[base + 2*p]     : stim_r[base + 2*p];
        b = imag ? stim_i[base + 2*p + 1] : stim_r[base + 2*p + 1];
        return (m % 2 == 0) ? a + b : a - b;
    endfunction

    // Record the inputs the DUT samples at each rising edge.
    always @(posedge clk) begin
        if (cyc < MAXC) begin
            stim_r[cyc] <= serial_in_r;
            stim_i[cyc] <= serial_in_i;
            stim_s[cyc] <= start_conv;
        end
        cyc <= cyc + 1;
    end

    // Compare process: every cycle, derive the expected outputs from the
    // length of the current uninterrupted start_conv run.
    always @(negedge clk) begin
        int t, len, idx, f, k, base;
        bit rst_hit, ev, efs;
        logic [DW-1:0] er, ei;
        t = cyc;
        if (t < MAXC) begin
            rst_hit = rst || (rst_events != seen_rst);
            seen_rst = rst_events;
            if (rst_hit) begin
                last_r = '0;
                last_i = '0;
            end
            len = 0;
            while (t - 1 - len >= 0 && stim_s[t - 1 - len]) len++;
            ev = !rst_hit && (len >= LAT);
            efs = 1'b0;
            er = last_r;
            ei = last_i;
            if (ev) begin
                idx  = len - LAT;
                f    = idx / NFFT;
                k    = idx % NFFT;
                base = t - len + NFFT * f;
                er   = model_bin(base, k, 1'b0);
                ei   = model_bin(base, k, 1'b1);
                efs  = (k == 0);
                last_r = er;
                last_i = ei;
            end
            cap_v[t]  = out_valid;
            cap_fs[t] = frame_start;
            cap_r[t]  = serial_out_r;
            cap_i[t]  = serial_out_i;
            checkOutput("out_valid", out_valid, ev);
            checkOutput("frame_start", frame_start, efs);
            checkOutput("serial_out_r", serial_out_r, er);
            checkOutput("serial_out_i", serial_out_i, ei);
        end
    end

    initial begin
        rst = 1'b1;
        start_conv = 1'b0;
        serial_in_r = '0;
        serial_in_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_frame_start", frame_start, 0);
        checkOutput("reset_out_r", serial_out_r, 0);
        rst = 1'b0;
        repeat (3) applyStimulus(1'b0, '0, '0);

        // Four back-to-back ramp frames, then zeros.
        applyStimulus(1'b1, '0, '0);
        c1 = cyc;
        for (int i = 1; i < 4 * NFFT; i++) applyStimulus(1'b1, DW'(i % NFFT), '0);
        for (int i = 0; i < 70; i++) applyStimulus(1'b1, '0, '0);
        repeat (5) applyStimulus(1'b0, '0, '0);
        checkOutput("ramp_valid_before", cap_v[c1 + 66], 0);
        checkOutput("ramp_valid_first", cap_v[c1 + 67], 1);
        checkOutput("ramp_fs_f0", cap_fs[c1 + 67], 1);
        checkOutput("ramp_X0", cap_r[c1 + 67], 1);
        checkOutput("ramp_X1", cap_r[c1 + 68], 65);
        checkOutput("ramp_X2", cap_r[c1 + 69], 33);
        checkOutput("ramp_X31", cap_r[c1 + 98], 125);
        checkOutput("ramp_X32", cap_r[c1 + 99], 32'h3FFFF);
        checkOutput("ramp_X32_imag", cap_i[c1 + 99], 0);
        checkOutput("ramp_fs_mid", cap_fs[c1 + 132], 0);
        checkOutput("ramp_fs_f1", cap_fs[c1 + 131], 1);
        checkOutput("ramp_fs_f2", cap_fs[c1 + 195], 1);
        checkOutput("ramp_fs_f3", cap_fs[c1 + 259], 1);
        checkOutput("ramp_f3_X1", cap_r[c1 + 260], 65);

        // Wrap-around pair, then an imaginary impulse frame, then zeros.
        applyStimulus(1'b1, 18'h1FFFF, '0);
        c2 = cyc;
        applyStimulus(1'b1, 18'h00001, '0);
        for (int i = 2; i < NFFT; i++) applyStimulus(1'b1, '0, '0);
        for (int i = 0; i < NFFT; i++)
            applyStimulus(1'b1, '0, (i == 2) ? 18'h01000 : 18'h00000);
        for (int i = 0; i < 70; i++) applyStimulus(1'b1, '0, '0);
        repeat (5) applyStimulus(1'b0, '0, '0);
        checkOutput("wrap_X0", cap_r[c2 + 67], 32'h20000);
        checkOutput("wrap_X1", cap_r[c2 + 68], 0);
        checkOutput("wrap_X32", cap_r[c2 + 99], 32'h1FFFE);
        checkOutput("imag_X16_i", cap_i[c2 + 131 + 16], 32'h01000);
        checkOutput("imag_X16_r", cap_r[c2 + 131 + 16], 0);
        checkOutput("imag_X48_i", cap_i[c2 + 131 + 48], 32'h01000);
        checkOutput("imag_X17_i", cap_i[c2 + 131 + 17], 0);

        // start_conv dropped during the second frame, then raised again.
        applyStimulus(1'b1, '0, '0);
        c3 = cyc;
        for (int i = 1; i < 100; i++) applyStimulus(1'b1, DW'(i % NFFT), '0);
        repeat (10) applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b1, '0, '0);
        d3 = cyc;
        for (int i = 1; i < 107; i++) applyStimulus(1'b1, DW'(i % NFFT), '0);
        repeat (5) applyStimulus(1'b0, '0, '0);
        checkOutput("drop_valid_last", cap_v[c3 + 100], 1);
        checkOutput("drop_valid_after", cap_v[c3 + 101], 0);
        checkOutput("restart_valid_before", cap_v[d3 + 66], 0);
        checkOutput("restart_valid_first", cap_v[d3 + 67], 1);
        checkOutput("restart_fs", cap_fs[d3 + 67], 1);
        checkOutput("restart_X0", cap_r[d3 + 67], 1);

        // Reset pulse between clock edges in the middle of a frame.
        applyStimulus(1'b1, '0, '0);
        c4 = cyc;
        for (int i = 1; i < 40; i++) applyStimulus(1'b1, DW'(i), '0);
        applyStimulus(1'b1, DW'(40), '0);
        #1;
        rst = 1'b1;
        rst_events++;
        #1;
        checkOutput("rst_pulse_valid", out_valid, 0);
        checkOutput("rst_pulse_fs", frame_start, 0);
        checkOutput("rst_pulse_out_r", serial_out_r, 0);
        checkOutput("rst_pulse_out_i", serial_out_i, 0);
        start_conv = 1'b0;
        #1;
        rst = 1'b0;
        repeat (5) applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b1, '0, '0);
        d4 = cyc;
        for (int i = 1; i < 136; i++) applyStimulus(1'b1, DW'(i % NFFT), '0);
        repeat (5) applyStimulus(1'b0, '0, '0);
        checkOutput("post_rst_valid_before", cap_v[d4 + 66], 0);
        checkOutput("post_rst_fs", cap_fs[d4 + 67], 1);
        checkOutput("post_rst_X0", cap_r[d4 + 67], 1);
        checkOutput("post_rst_X1", cap_r[d4 + 68], 65);
        checkOutput("post_rst_X2", cap_r[d4 + 69], 33);

        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
        $finish;
    end

endmodule
